// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller beside the ID stage: operand forward selects,
// load-use stall and redirect flush sequencing, saturating stall/flush event counters.
module hazard_fwd_ctrl #(
    parameter int NSTAGE      = 3,
    parameter int RW          = 5,
    parameter int LOAD_LAT    = 2,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16,
    parameter int SW          = $clog2(NSTAGE + 1)
) (
    input  logic                 in_CLK,
    input  logic                 in_RST,
    input  logic                 in_EN,
    input  logic                 in_RS_USE,
    input  logic [RW-1:0]        in_RS,
    input  logic                 in_RT_USE,
    input  logic [RW-1:0]        in_RT,
    input  logic                 in_ST,
    input  logic [NSTAGE-1:0]    in_SRC_WE,
    input  logic [NSTAGE*RW-1:0] in_SRC_RD,
    input  logic [NSTAGE-1:0]    in_SRC_LD,
    input  logic                 in_REDIR,
    output logic [SW-1:0]        out_FWD_RS,
    output logic [SW-1:0]        out_FWD_RT,
    output logic                 out_STALL,
    output logic                 out_FLUSH,
    output logic                 out_PEN,
    output logic [CNT_W-1:0]     out_STALL_CNT,
    output logic [CNT_W-1:0]     out_FLUSH_CNT
);

    // state | meaning
    // IDLE  | no sequence active; stall only while the hazard is live
    // STALL | remainder of a load-use stall, stall_cnt_q cycles left
    // FLUSH | wrong-path flush of IF/ID, flush_cnt_q cycles left
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] STALL = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam logic [3:0] STALL_LOAD = 4'(LOAD_LAT - 1);
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_DEPTH);

    logic [1:0]       state_q, state_d;
    logic [3:0]       stall_cnt_q, stall_cnt_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] stall_ev_q, stall_ev_d;
    logic [CNT_W-1:0] flush_ev_q, flush_ev_d;

    logic [SW-1:0] fwd_rs, fwd_rt;
    logic          haz_rs, haz_rt, haz;
    logic          stall, flush;

    // Scan farthest to nearest so the nearest matching source wins.
    always_comb begin
        fwd_rs = '0;
        fwd_rt = '0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (in_RS_USE && (in_RS != '0) && in_SRC_WE[k-1] &&
                (in_SRC_RD[(k-1)*RW +: RW] == in_RS))
                fwd_rs = SW'(k);
            if (in_RT_USE && (in_RT != '0) && in_SRC_WE[k-1] &&
                (in_SRC_RD[(k-1)*RW +: RW] == in_RT))
                fwd_rt = SW'(k);
        end
    end

    always_comb begin
        haz_rs = 1'b0;
        haz_rt = 1'b0;
        for (int k = 1; k <= NSTAGE; k++) begin
            if (fwd_rs == SW'(k) && in_SRC_LD[k-1])
                haz_rs = 1'b1;
            if (fwd_rt == SW'(k) && in_SRC_LD[k-1])
                haz_rt = 1'b1;
        end
        // Store data is picked up at MEM, so a pending load on RT does not block it.
        if (in_ST)
            haz_rt = 1'b0;
        haz = haz_rs | haz_rt;
    end

    always_comb begin
        stall = (haz || state_q == STALL) && (state_q != FLUSH) && in_EN && in_RST;
        flush = (state_q == FLUSH) && in_EN && in_RST;
    end

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (in_EN) begin
            if (in_REDIR) begin
                state_d     = FLUSH;
                flush_cnt_d = FLUSH_LOAD;
                stall_cnt_d = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (haz && LOAD_LAT > 1) begin
                            state_d     = STALL;
                            stall_cnt_d = STALL_LOAD;
                        end
                    end
                    STALL: begin
                        stall_cnt_d = stall_cnt_q - 4'd1;
                        if (stall_cnt_q <= 4'd1) begin
                            state_d     = IDLE;
                            stall_cnt_d = '0;
                        end
                    end
                    FLUSH: begin
                        flush_cnt_d = flush_cnt_q - 4'd1;
                        if (flush_cnt_q <= 4'd1) begin
                            state_d     = IDLE;
                            flush_cnt_d = '0;
                        end
                    end
                    default: begin
                        state_d     = IDLE;
                        stall_cnt_d = '0;
                        flush_cnt_d = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        stall_ev_d = stall_ev_q;
        flush_ev_d = flush_ev_q;
        if (stall && stall_ev_q != '1)
            stall_ev_d = stall_ev_q + 1'b1;
        if (flush && flush_ev_q != '1)
            flush_ev_d = flush_ev_q + 1'b1;
    end

    always_ff @(posedge in_CLK or negedge in_RST) begin
        if (!in_RST) begin
            state_q     <= IDLE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            stall_ev_q  <= '0;
            flush_ev_q  <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            stall_ev_q  <= stall_ev_d;
            flush_ev_q  <= flush_ev_d;
        end
    end

    assign out_FWD_RS    = fwd_rs;
    assign out_FWD_RT    = fwd_rt;
    assign out_STALL     = stall;
    assign out_FLUSH     = flush;
    assign out_PEN       = in_EN & in_RST & ~stall;
    assign out_STALL_CNT = stall_ev_q;
    assign out_FLUSH_CNT = flush_ev_q;

endmodule
